hazard_unit: RTL and testbench



---
 rtl/hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_hazard_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard controller sitting beside the ID stage. It drives the PC
// register's next_pc/pc_write, the IF/ID write/flush controls and the ID/EX
// bubble. It also tracks how long the multi-cycle mul/div unit stays busy.
//
// Ports:
//   clock, reset        - system clock (rising edge), synchronous active-high reset
//   prog_count          - current PC
//   id_rs, id_rt        - source register fields of the instruction in ID
//   id_uses_rt          - ID instruction reads rt as a source
//   id_muldiv           - ID instruction is mult/multu/div/divu
//   id_reads_hilo       - ID instruction is mfhi/mflo
//   ex_mem_read, ex_rt  - EX holds a load and this is its destination register
//   branch_taken        - EX resolved a taken branch
//   branch_target       - target address of that branch
//   jump, jump_target   - ID holds j/jal/jr and this is its target
//   next_pc, pc_write   - PC register load value and load enable
//   if_id_write         - IF/ID load enable
//   if_id_flush         - clear IF/ID to NOP
//   id_ex_bubble        - insert NOP into ID/EX
//   muldiv_busy         - mul/div unit occupied
//   stall_count, flush_count - present only when HAZARD_STATS_EN is defined;
//                         saturating counts of stall cycles and flush cycles
//
// Optional feature macro: HAZARD_STATS_EN
//
// state  | meaning
// RUN    | mul/div idle; a mul/div in ID may issue
// MULDIV | mul/div in flight; hi/lo readers and new mul/div ops stall

module hazard_unit #(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] prog_count,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_muldiv,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] next_pc,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        muldiv_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_e;

    localparam logic [7:0] REMAIN_INIT = 8'(MULDIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;

    logic        load_use;
    logic        muldiv_issue;
    logic [31:0] seq_pc;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign seq_pc   = prog_count + 32'd4;

    // A taken branch squashes the ID instruction, so it must not start mul/div.
    assign muldiv_issue = (state_q == RUN) && id_muldiv && !branch_taken && !load_use;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            remaining_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            RUN: begin
                if (muldiv_issue) begin
                    state_d     = MULDIV;
                    remaining_d = REMAIN_INIT;
                end
            end
            MULDIV: begin
                if (remaining_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    remaining_d = remaining_q - 8'd1;
                end
            end
            default: begin
                state_d     = RUN;
                remaining_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        next_pc      = seq_pc;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        muldiv_busy  = (state_q == MULDIV);
        if (reset) begin
            next_pc     = 32'd0;
            muldiv_busy = 1'b0;
        end else if (branch_taken) begin
            next_pc      = branch_target;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || ((state_q == MULDIV) && (id_reads_hilo || id_muldiv))) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (jump) begin
            next_pc     = jump_target;
            if_id_flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, flush_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            if (!pc_write && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (if_id_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    localparam int C = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] prog_count;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_muldiv, id_reads_hilo, ex_mem_read;
    logic        branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] next_pc;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, muldiv_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count;
    logic [31:0] m_stall = 0, m_flush = 0;
`endif

    always #5 clock = ~clock;

    hazard_unit #(.MULDIV_CYCLES(C)) dut (
        .clock(clock), .reset(reset), .prog_count(prog_count),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .id_reads_hilo(id_reads_hilo),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .next_pc(next_pc), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .muldiv_busy(muldiv_busy)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: cycles of mul/div occupancy still ahead.
    int busy_left = 0;
    logic [31:0] e_npc;
    logic        e_pcw, e_ifw, e_fl, e_bub, e_busy;

    function automatic logic model_load_use();
        return ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic void model_out();
        e_busy = busy_left > 0;
        e_npc  = prog_count + 32'd4;
        e_pcw  = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        if (reset) begin
            e_npc = 0; e_busy = 0;
        end else if (branch_taken) begin
            e_npc = branch_target; e_fl = 1; e_bub = 1;
        end else if (model_load_use() || (e_busy && (id_reads_hilo || id_muldiv))) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1;
        end else if (jump) begin
            e_npc = jump_target; e_fl = 1;
        end
    endfunction

    function automatic void model_edge();
        model_out();
        if (reset) begin
            busy_left = 0;
`ifdef HAZARD_STATS_EN
            m_stall = 0; m_flush = 0;
`endif
        end else begin
`ifdef HAZARD_STATS_EN
            if (!e_pcw && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (e_fl && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
            if (busy_left > 0) busy_left--;
            else if (id_muldiv && !branch_taken && !model_load_use()) busy_left = C;
        end
    endfunction

    task automatic check1(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(string nm);
        model_out();
        check1({nm, ".next_pc"}, next_pc, e_npc);
        check1({nm, ".pc_write"}, 32'(pc_write), 32'(e_pcw));
        check1({nm, ".if_id_write"}, 32'(if_id_write), 32'(e_ifw));
        check1({nm, ".if_id_flush"}, 32'(if_id_flush), 32'(e_fl));
        check1({nm, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
        check1({nm, ".muldiv_busy"}, 32'(muldiv_busy), 32'(e_busy));
`ifdef HAZARD_STATS_EN
        check1({nm, ".stall_count"}, stall_count, m_stall);
        check1({nm, ".flush_count"}, flush_count, m_flush);
`endif
    endtask

    task automatic finish_cycle();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic step(string nm);
        @(negedge clock);
        check_all(nm);
        finish_cycle();
    endtask

    task automatic set_idle();
        reset = 0; prog_count = 32'h100; id_rs = 1; id_rt = 2; id_uses_rt = 0;
        id_muldiv = 0; id_reads_hilo = 0; ex_mem_read = 0; ex_rt = 0;
        branch_taken = 0; branch_target = 32'h400; jump = 0; jump_target = 32'h2000;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs, rt;
        logic        uses_rt, mem_read;
        logic [4:0]  xrt;
        logic        br, jmp;
        logic [31:0] x_npc;
        logic        x_pcw, x_ifw, x_fl, x_bub;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic [4:0] rs, logic [4:0] rt,
                                logic uses_rt, logic mem_read, logic [4:0] xrt,
                                logic br, logic jmp, logic [31:0] x_npc,
                                logic x_pcw, logic x_ifw, logic x_fl, logic x_bub);
        vec_t v;
        v.pc = pc; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.mem_read = mem_read;
        v.xrt = xrt; v.br = br; v.jmp = jmp; v.x_npc = x_npc;
        v.x_pcw = x_pcw; v.x_ifw = x_ifw; v.x_fl = x_fl; v.x_bub = x_bub;
        return v;
    endfunction

    vec_t vecs[9];

    initial begin
        // branch_target fixed at 0x400, jump_target at 0x2000
        vecs[0] = mk(32'h100, 8, 2, 0, 1, 8, 0, 0, 32'h104, 0, 0, 0, 1);
        vecs[1] = mk(32'h100, 0, 2, 0, 1, 0, 0, 0, 32'h104, 1, 1, 0, 0);
        vecs[2] = mk(32'h200, 3, 9, 1, 1, 9, 0, 0, 32'h204, 0, 0, 0, 1);
        vecs[3] = mk(32'h200, 3, 9, 0, 1, 9, 0, 0, 32'h204, 1, 1, 0, 0);
        vecs[4] = mk(32'h100, 8, 2, 0, 1, 8, 1, 0, 32'h400, 1, 1, 1, 1);
        vecs[5] = mk(32'h40, 1, 2, 0, 0, 0, 0, 1, 32'h2000, 1, 1, 1, 0);
        vecs[6] = mk(32'hFFFF_FFFC, 1, 2, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0);
        vecs[7] = mk(32'h300, 5, 2, 0, 1, 5, 0, 1, 32'h304, 0, 0, 0, 1);
        vecs[8] = mk(32'h300, 1, 2, 0, 0, 0, 1, 1, 32'h400, 1, 1, 1, 1);

        set_idle();
        reset = 1; branch_taken = 1;
        step("rst0");
        @(negedge clock);
        check1("rst1.next_pc", next_pc, 32'h0);
        check1("rst1.pc_write", 32'(pc_write), 32'd1);
        check1("rst1.flush", 32'(if_id_flush), 32'd0);
        check_all("rst1");
        finish_cycle();
        reset = 0; branch_taken = 0; prog_count = 32'h100;
        @(negedge clock);
        check1("post_rst.next_pc", next_pc, 32'h104);
        check_all("post_rst");
        finish_cycle();

        for (int i = 0; i < 9; i++) begin
            set_idle();
            prog_count = vecs[i].pc; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rt = vecs[i].uses_rt; ex_mem_read = vecs[i].mem_read;
            ex_rt = vecs[i].xrt; branch_taken = vecs[i].br; jump = vecs[i].jmp;
            @(negedge clock);
            check1($sformatf("vec%0d.next_pc", i), next_pc, vecs[i].x_npc);
            check1($sformatf("vec%0d.pc_write", i), 32'(pc_write), 32'(vecs[i].x_pcw));
            check1($sformatf("vec%0d.if_id_write", i), 32'(if_id_write), 32'(vecs[i].x_ifw));
            check1($sformatf("vec%0d.flush", i), 32'(if_id_flush), 32'(vecs[i].x_fl));
            check1($sformatf("vec%0d.bubble", i), 32'(id_ex_bubble), 32'(vecs[i].x_bub));
            check_all($sformatf("vec%0d", i));
            finish_cycle();
        end

        // Load-use stall lasts one cycle: the load then leaves EX.
        set_idle(); ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        step("lu_stall");
        ex_mem_read = 0;
        @(negedge clock);
        check1("lu_release.pc_write", 32'(pc_write), 32'd1);
        check_all("lu_release");
        finish_cycle();

        // mul/div issue at N, hi/lo reader from N+2 stalls until busy drops.
        set_idle(); id_muldiv = 1;
        step("md_issue");
        id_muldiv = 0;
        step("md_n1");
        id_reads_hilo = 1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clock);
            check1($sformatf("md_n%0d.busy", k), 32'(muldiv_busy), 32'd1);
            check1($sformatf("md_n%0d.pc_write", k), 32'(pc_write), 32'd0);
            check_all($sformatf("md_n%0d", k));
            finish_cycle();
        end
        @(negedge clock);
        check1("md_n5.busy", 32'(muldiv_busy), 32'd0);
        check1("md_n5.pc_write", 32'(pc_write), 32'd1);
        check_all("md_n5");
        finish_cycle();

        // Branch during MULDIV keeps the op in flight; issue blocked by branch.
        set_idle(); id_muldiv = 1;
        step("mdb_issue");
        id_muldiv = 0; branch_taken = 1;
        step("mdb_branch");
        branch_taken = 0;
        for (int k = 0; k < C; k++) step("mdb_drain");
        id_muldiv = 1; branch_taken = 1;
        step("md_blocked_br");
        id_muldiv = 0; branch_taken = 0;
        step("md_blocked_br_after");

        // Reset mid-MULDIV.
        id_muldiv = 1;
        step("mdr_issue");
        id_muldiv = 0;
        step("mdr_busy");
        reset = 1;
        step("mdr_reset");
        reset = 0;
        @(negedge clock);
        check1("mdr_after.busy", 32'(muldiv_busy), 32'd0);
        check_all("mdr_after");
        finish_cycle();

`ifdef HAZARD_STATS_EN
        set_idle(); reset = 1;
        step("st_rst");
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            set_idle(); ex_mem_read = 1; ex_rt = 4; id_rs = 4;
            step("st_lu");
            set_idle();
            step("st_idle");
        end
        for (int k = 0; k < 2; k++) begin
            set_idle(); branch_taken = 1;
            step("st_br");
        end
        set_idle();
        check1("stats.stall_count", stall_count, 32'd3);
        check1("stats.flush_count", flush_count, 32'd2);
        reset = 1;
        step("st_rst2");
        check1("stats_rst.stall_count", stall_count, 32'd0);
        check1("stats_rst.flush_count", flush_count, 32'd0);
        reset = 0;
`endif

        // Randomised run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            prog_count    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_uses_rt    = 1'($urandom_range(0, 1));
            id_muldiv     = ($urandom_range(0, 7) == 0);
            id_reads_hilo = ($urandom_range(0, 3) == 0);
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_rt         = 5'($urandom_range(0, 7));
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = $urandom();
            jump          = ($urandom_range(0, 5) == 0);
            jump_target   = $urandom();
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
